// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer
//   Iterative radix-2 sequencer for the RV32M MUL/DIV/REM family. Runs beside
//   the single-cycle ALU. Each operation takes a fixed WIDTH+2 cycles after
//   acceptance: WIDTH iterations (CALC), one sign-fix cycle (FIX) and a
//   one-cycle done pulse (DONE).
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   funct3  in   M-extension op (000 MUL .. 111 REMU)
//   src_a   in   rs1: multiplicand / dividend
//   src_b   in   rs2: multiplier / divisor
//   flush   in   abort the in-flight operation
//   busy    out  operation in flight (CALC or FIX)
//   stall   out  pipeline stall request, also high in the request cycle
//   done    out  one-cycle pulse, result valid
//   result  out  registered result, held until the next completed operation
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0]   acc_q, acc_d;        // product, or quotient in the low half
    logic [WIDTH-1:0]     rem_q, rem_d;        // settled partial remainder
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;  // raw dividend for the divide-by-zero remainder
    logic                 neg_q, neg_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;

    // Two's-complement magnitude when the operand is interpreted as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return (is_signed && (sv < 0)) ? -v : v;
    endfunction

    // Operand classification for the request cycle.
    logic             a_sgn, b_sgn, is_div, is_rem, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign is_div = funct3[2];
    assign is_rem = funct3[2] & funct3[1];
    assign neg_a  = a_sgn & src_a[WIDTH-1];
    assign neg_b  = b_sgn & src_b[WIDTH-1];
    assign mag_a  = magnitude(src_a, a_sgn);
    assign mag_b  = magnitude(src_b, b_sgn);

    // One radix-2 iteration of each algorithm.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // Sign correction and output selection.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, fix_val;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_q ? -rem_q : rem_q;

    always_comb begin
        fix_val = prod_fix[WIDTH-1:0];
        case (op_q)
            3'b000:                 fix_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = dbz_q ? '1 : (ovf_q ? MIN_NEG : quo_fix);
            default:                fix_val = dbz_q ? orig_a_q : (ovf_q ? '0 : rem_fix);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !flush) state_d = S_CALC;
            S_CALC:  if (flush) state_d = S_IDLE;
                     else if (cnt_q == LAST_CNT) state_d = S_FIX;
            S_FIX:   state_d = flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = (state_q == S_CALC) || (state_q == S_FIX);
        stall = busy || (start && (state_q == S_IDLE));
        done  = (state_q == S_DONE);
    end

    assign result = result_q;

    // Datapath next values
    always_comb begin
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        orig_a_d = orig_a_q;
        neg_d    = neg_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d     = funct3;
                    opnd_d   = is_div ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    rem_d    = '0;
                    orig_a_d = src_a;
                    // Remainder sign follows the dividend; everything else is the XOR.
                    neg_d    = is_rem ? neg_a : (neg_a ^ neg_b);
                    dbz_d    = is_div && (src_b == '0);
                    ovf_d    = is_div && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
                    cnt_d    = '0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (!flush) result_d = fix_val;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            orig_a_q <= '0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            orig_a_q <= orig_a_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference model: RISC-V M-extension semantics from plain wide arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (f3)
            3'b000: begin p = ua * ub;            r = p[31:0];  end
            3'b001: begin p = sa * sb;            r = p[63:32]; end
            3'b010: begin p = sa * longint'(ub);  r = p[63:32]; end
            3'b011: begin p = ua * ub;            r = p[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = 32'(ia / ib);
            end
            3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = 32'(ia % ib);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issues one operation from an IDLE cycle and tracks it to completion.
    // poke>0 raises a second, different start in that busy cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input string tag);
        logic [31:0] exp_v, res_done;
        int          done_cyc, busy_cnt, stall_bad, done_cnt;
        exp_v = ref_op(f3, a, b);
        done_cyc = 0; busy_cnt = 0; stall_bad = 0; done_cnt = 0; res_done = '0;
        funct3 = f3; src_a = a; src_b = b; flush = 1'b0; start = 1'b1;
        #1;
        chk({tag, "_stall_req"}, {31'b0, stall}, 32'd1);
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            start = (n == poke);
            if (n == poke) begin
                funct3 = f3 ^ 3'b101;
                src_a  = $urandom;
                src_b  = $urandom;
            end
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (stall !== busy) stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = n;
                    res_done = result;
                end
            end
            if (done_cyc != 0 && n > done_cyc) break;
        end
        start = 1'b0;
        chk({tag, "_latency"},   done_cyc,  32'd34);
        chk({tag, "_busy_cyc"},  busy_cnt,  32'd33);
        chk({tag, "_stall"},     stall_bad, 32'd0);
        chk({tag, "_done_cnt"},  done_cnt,  32'd1);
        chk({tag, "_result"},    res_done,  exp_v);
        chk({tag, "_held"},      result,    exp_v);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          dcnt;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; src_a = '0; src_b = '0;
        #2;
        chk("rst_busy",   {31'b0, busy},  32'd0);
        chk("rst_done",   {31'b0, done},  32'd0);
        chk("rst_stall",  {31'b0, stall}, 32'd0);
        chk("rst_result", result,         32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases; the MUL run also carries an ignored second start.
        run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 5, "mul");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu");
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulh");
        run_op(3'b010, 32'hFFFFFFFE, 32'h80000001, 0, "mulhsu");
        run_op(3'b100, 32'hFFFFFFEC, 32'h00000006, 0, "div");
        run_op(3'b110, 32'hFFFFFFEC, 32'h00000006, 0, "rem");
        run_op(3'b100, 32'h12345678, 32'h00000000, 0, "div_by0");
        run_op(3'b111, 32'h12345678, 32'h00000000, 0, "remu_by0");
        run_op(3'b110, 32'hFFFFFFF0, 32'h00000000, 0, "rem_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, "rem_ovf");
        run_op(3'b101, 32'd100,      32'd7,        0, "divu");

        // Abort a DIVU with flush in cycle 10.
        funct3 = 3'b101; src_a = 32'hDEADBEEF; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", dcnt,   32'd0);
        chk("abort_result",  result, 32'h0000000E);

        // start together with flush in IDLE is ignored.
        funct3 = 3'b000; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        #1;
        chk("startflush_busy", {31'b0, busy}, 32'd0);

        // Randomized operations with corner-value injection.
        for (int i = 0; i < 14; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(rf, ra, rb, (i % 3 == 0) ? 7 : 0, "rnd");
        end

        // Asynchronous reset in the middle of CALC.
        funct3 = 3'b011; src_a = 32'hFFFF0000; src_b = 32'h00FF00FF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'b0, busy}, 32'd0);
        chk("arst_done",   {31'b0, done}, 32'd0);
        chk("arst_result", result,        32'd0);
        @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (done === 1'b1) dcnt++;
        end
        chk("arst_no_done", dcnt,   32'd0);
        chk("arst_result2", result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
